piece_drop_engine: RTL and testbench

- Parametrised successor of the single-piece fall logic.
- Spawns one of seven tetrominoes at the top of a ROWS x COLS playfield and advances it one row per gravity tick.
- Detects landing by collision against the live board occupancy, not a fixed per-shape floor, and reports the landing row.
- Sits between the game FSM (start/tick/board) and the board-merge/line-clear stage (piece_mask/landed).

---
 rtl/piece_drop_engine.sv | 193 +++++++++++++++++++
 tb/tb_piece_drop_engine.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piece_drop_engine.sv
// Single falling tetromino: spawns at the top, drops one row per tick, lands on board collision.
// Optional LOCK_DELAY_EN adds a lock-delay state; board/mask bit index is row*COLS + col.
module piece_drop_engine #(
    parameter int ROWS       = 20,
    parameter int COLS       = 10,
    parameter int SPAWN_COL  = 4,
    parameter int LOCK_TICKS = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic [2:0]               i_piece_type,
    input  logic                     i_tick,
    input  logic [ROWS*COLS-1:0]     i_board,
    output logic [ROWS*COLS-1:0]     o_piece_mask,
    output logic [$clog2(ROWS)-1:0]  o_piece_row,
    output logic                     o_busy,
    output logic                     o_landed,
    output logic [$clog2(ROWS)-1:0]  o_collision_row,
    output logic                     o_game_over
);
    localparam int RW = $clog2(ROWS);

    if (SPAWN_COL < 1 || SPAWN_COL > COLS - 3) begin : g_bad_spawn_col
        $error("piece_drop_engine: SPAWN_COL out of range");
    end
    if (LOCK_TICKS < 1) begin : g_bad_lock_ticks
        $error("piece_drop_engine: LOCK_TICKS must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN,
        S_FALL,
`ifdef LOCK_DELAY_EN
        S_LOCK,
`endif
        S_LAND
    } state_t;

    state_t          r_state;
    logic [2:0]      r_type;
    logic [RW-1:0]   r_row;
    logic [RW-1:0]   r_coll;
    logic            r_busy;
    logic            r_landed;
    logic            r_game_over;
`ifdef LOCK_DELAY_EN
    localparam int LW = $clog2(LOCK_TICKS + 1);
    logic [LW-1:0]   r_lock_cnt;
`endif

    logic [15:0]     w_shape;
    logic [RW:0]     w_h;
    logic [RW:0]     w_eval_row;
    logic            w_fits;

    // Shape bitmap: bit dr*4 + (dc+1), covering dr 0..3 and dc -1..2.
    function automatic logic [15:0] shape_bits(input logic [2:0] t);
        case (t)
            3'd0:    return 16'h2222;
            3'd1:    return 16'h0066;
            3'd2:    return 16'h0622;
            3'd3:    return 16'h0644;
            3'd4:    return 16'h006C;
            3'd5:    return 16'h00C6;
            3'd6:    return 16'h0072;
            default: return 16'h0000;
        endcase
    endfunction

    always_comb begin
        w_shape = shape_bits(r_type);
        case (r_type)
            3'd0:        w_h = (RW+1)'(4);
            3'd2, 3'd3:  w_h = (RW+1)'(3);
            default:     w_h = (RW+1)'(2);
        endcase
        w_eval_row = (r_state == S_SPAWN) ? {1'b0, r_row} : {1'b0, r_row} + 1'b1;
    end

    always_comb begin
        w_fits = 1'b1;
        for (int dr = 0; dr < 4; dr++) begin
            for (int j = 0; j < 4; j++) begin
                if (w_shape[dr*4 + j]) begin
                    if (int'(w_eval_row) + dr >= ROWS)
                        w_fits = 1'b0;
                    else if (i_board[(int'(w_eval_row) + dr)*COLS + SPAWN_COL - 1 + j])
                        w_fits = 1'b0;
                end
            end
        end
    end

    // Mask is a pure decode of registered state so the merge stage sees it in the LAND cycle.
    always_comb begin
        o_piece_mask = '0;
        if (r_state != S_IDLE) begin
            for (int dr = 0; dr < 4; dr++) begin
                for (int j = 0; j < 4; j++) begin
                    if (w_shape[dr*4 + j] && (int'(r_row) + dr < ROWS))
                        o_piece_mask[(int'(r_row) + dr)*COLS + SPAWN_COL - 1 + j] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_type      <= 3'd0;
            r_row       <= '0;
            r_coll      <= '0;
            r_busy      <= 1'b0;
            r_landed    <= 1'b0;
            r_game_over <= 1'b0;
`ifdef LOCK_DELAY_EN
            r_lock_cnt  <= '0;
`endif
        end else begin
            r_landed <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start && !r_game_over && (i_piece_type != 3'd7)) begin
                        r_type  <= i_piece_type;
                        r_row   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SPAWN;
                    end
                end
                S_SPAWN: begin
                    if (w_fits) begin
                        r_state <= S_FALL;
                    end else begin
                        r_game_over <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                S_FALL: begin
                    if (i_tick) begin
                        if (w_fits) begin
                            r_row <= r_row + 1'b1;
                        end else begin
`ifdef LOCK_DELAY_EN
                            r_lock_cnt <= LW'(LOCK_TICKS);
                            r_state    <= S_LOCK;
`else
                            r_landed <= 1'b1;
                            r_coll   <= RW'({1'b0, r_row} + w_h - 1'b1);
                            r_state  <= S_LAND;
`endif
                        end
                    end
                end
`ifdef LOCK_DELAY_EN
                S_LOCK: begin
                    if (i_tick) begin
                        if (w_fits) begin
                            r_row      <= r_row + 1'b1;
                            r_lock_cnt <= '0;
                            r_state    <= S_FALL;
                        end else if (r_lock_cnt == LW'(1)) begin
                            r_lock_cnt <= '0;
                            r_landed   <= 1'b1;
                            r_coll     <= RW'({1'b0, r_row} + w_h - 1'b1);
                            r_state    <= S_LAND;
                        end else begin
                            r_lock_cnt <= r_lock_cnt - 1'b1;
                        end
                    end
                end
`endif
                S_LAND: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_piece_row     = r_row;
    assign o_busy          = r_busy;
    assign o_landed        = r_landed;
    assign o_collision_row = r_coll;
    assign o_game_over     = r_game_over;

endmodule

// File: tb/tb_piece_drop_engine.sv
// Bench for piece_drop_engine: directed scenarios plus random play against a cell-list reference model.
module tb_piece_drop_engine;
    localparam int ROWS = 20;
    localparam int COLS = 10;
    localparam int SPAWN = 4;
    localparam int NB = ROWS * COLS;
`ifdef LOCK_DELAY_EN
    localparam int LOCK_LIMIT = 3;
`else
    localparam int LOCK_LIMIT = 1;
`endif
    localparam int P_IDLE = 0, P_SPAWN = 1, P_FALL = 2, P_LAND = 3;

    logic          clk, rst_n, start, tick;
    logic [2:0]    ptype;
    logic [NB-1:0] board;
    logic [NB-1:0] piece_mask;
    logic [4:0]    piece_row, collision_row;
    logic          busy, landed, game_over;

    piece_drop_engine dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_piece_type(ptype),
        .i_tick(tick), .i_board(board), .o_piece_mask(piece_mask),
        .o_piece_row(piece_row), .o_busy(busy), .o_landed(landed),
        .o_collision_row(collision_row), .o_game_over(game_over)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // Shape cells (dr, dc) relative to the anchor, one row per piece type.
    int tab_dr [7][4] = '{'{0,1,2,3}, '{0,0,1,1}, '{0,1,2,2}, '{0,1,2,2}, '{0,0,1,1}, '{0,0,1,1}, '{0,1,1,1}};
    int tab_dc [7][4] = '{'{0,0,0,0}, '{0,1,0,1}, '{0,0,0,1}, '{1,1,1,0}, '{1,2,0,1}, '{0,1,1,2}, '{0,-1,0,1}};

    int m_phase, m_type, m_row, m_coll, m_streak;
    bit m_go;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int height(int t);
        int h = 0;
        for (int k = 0; k < 4; k++)
            if (tab_dr[t][k] + 1 > h) h = tab_dr[t][k] + 1;
        return h;
    endfunction

    function automatic bit m_fits(int t, int r);
        for (int k = 0; k < 4; k++) begin
            int rr = r + tab_dr[t][k];
            int cc = SPAWN + tab_dc[t][k];
            if (rr >= ROWS) return 1'b0;
            if (board[rr*COLS + cc]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [NB-1:0] shape_mask(int t, int r);
        logic [NB-1:0] m = '0;
        for (int k = 0; k < 4; k++)
            m[(r + tab_dr[t][k])*COLS + SPAWN + tab_dc[t][k]] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE; m_type = 0; m_row = 0; m_coll = 0; m_streak = 0; m_go = 0;
    endtask

    task automatic model_clock();
        case (m_phase)
            P_IDLE: if (start && !m_go && ptype != 3'd7) begin
                m_type = int'(ptype); m_row = 0; m_phase = P_SPAWN;
            end
            P_SPAWN: if (m_fits(m_type, 0)) begin
                m_phase = P_FALL; m_streak = 0;
            end else begin
                m_go = 1; m_phase = P_IDLE;
            end
            P_FALL: if (tick) begin
                if (m_fits(m_type, m_row + 1)) begin
                    m_row++; m_streak = 0;
                end else begin
                    m_streak++;
                    if (m_streak == LOCK_LIMIT) begin
                        m_phase = P_LAND;
                        m_coll = m_row + height(m_type) - 1;
                    end
                end
            end
            default: m_phase = P_IDLE;
        endcase
    endtask

    task automatic compare_all();
        chk("busy", busy, m_phase != P_IDLE);
        chk("landed", landed, m_phase == P_LAND);
        chk("piece_row", piece_row, m_row);
        chk("collision_row", collision_row, m_coll);
        chk("game_over", game_over, m_go);
        chk("piece_mask", piece_mask, (m_phase == P_IDLE) ? '0 : shape_mask(m_type, m_row));
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        @(negedge clk);
        compare_all();
    endtask

    // Called at a falling edge; reset is asserted asynchronously mid-cycle.
    task automatic reset_dut();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_landed", landed, 1'b0);
        chk("rst_row", piece_row, 0);
        chk("rst_coll", collision_row, 0);
        chk("rst_game_over", game_over, 1'b0);
        chk("rst_mask", piece_mask, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic spawn(input int t);
        start = 1'b1; ptype = 3'(t);
        step();
        start = 1'b0;
        step();
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) step();
        tick = 1'b0;
    endtask

    task automatic tick_until_landed(input int limit, output int n);
        n = 0;
        tick = 1'b1;
        while (!landed && n < limit) begin
            step();
            n++;
        end
        tick = 1'b0;
    endtask

    task automatic rand_board();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                int thr = (r < 2) ? 2 : ((r < 12) ? 4 : 25);
                board[r*COLS + c] = ($urandom_range(0, 99) < thr);
            end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NB-1:0] exp_mask;
        int n;
        clk = 0; rst_n = 0; start = 0; ptype = 0; tick = 0; board = '0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst_n = 1'b1;
        step();

        // Line on an empty board falls to row 16 and lands on the 17th tick.
        spawn(0);
        ticks(16);
        chk("s1_row16", piece_row, 16);
        exp_mask = '0;
        for (int r = 16; r < 20; r++) exp_mask[r*COLS + 4] = 1'b1;
        chk("s1_mask", piece_mask, exp_mask);
        ticks(1);
        chk("s1_landed", landed, 1'b1);
        chk("s1_coll", collision_row, 19);
        step();
        chk("s1_idle_busy", busy, 1'b0);
        chk("s1_landed_pulse", landed, 1'b0);

        // Square resting on a full bottom row.
        for (int c = 0; c < COLS; c++) board[19*COLS + c] = 1'b1;
        spawn(1);
        tick_until_landed(60, n);
        chk("s2_ticks", n, 17 + LOCK_LIMIT);
        chk("s2_row", piece_row, 17);
        chk("s2_coll", collision_row, 18);
        exp_mask = '0;
        exp_mask[17*COLS + 4] = 1'b1; exp_mask[17*COLS + 5] = 1'b1;
        exp_mask[18*COLS + 4] = 1'b1; exp_mask[18*COLS + 5] = 1'b1;
        chk("s2_mask", piece_mask, exp_mask);
        step();

`ifdef LOCK_DELAY_EN
        // Lock delay: clearing the floor between blocked ticks lets the piece resume.
        spawn(1);
        ticks(17);
        ticks(2);
        chk("lk_not_landed", landed, 1'b0);
        chk("lk_busy", busy, 1'b1);
        board = '0;
        ticks(1);
        chk("lk_resume_row", piece_row, 18);
        tick_until_landed(20, n);
        chk("lk_blocked_ticks", n, 3);
        chk("lk_coll", collision_row, 19);
        step();
`endif

        // Spawn collision sets game_over; later starts are ignored.
        board = '0;
        board[1*COLS + 4] = 1'b1;
        spawn(6);
        chk("s3_game_over", game_over, 1'b1);
        chk("s3_busy", busy, 1'b0);
        chk("s3_landed", landed, 1'b0);
        board = '0;
        start = 1'b1; ptype = 3'd2;
        step();
        start = 1'b0;
        chk("s3_start_ignored", busy, 1'b0);
        step();
        reset_dut();
        chk("s3_go_cleared", game_over, 1'b0);

        // Invalid type, idle ticks, start while busy.
        start = 1'b1; ptype = 3'd7;
        step();
        start = 1'b0;
        chk("s4_type7", busy, 1'b0);
        ticks(3);
        chk("s4_idle_row", piece_row, 0);
        spawn(0);
        ticks(3);
        start = 1'b1; ptype = 3'd3;
        step();
        start = 1'b0;
        step();
        exp_mask = '0;
        for (int r = 3; r < 7; r++) exp_mask[r*COLS + 4] = 1'b1;
        chk("s4_type_kept", piece_mask, exp_mask);
        tick_until_landed(40, n);
        chk("s4_coll", collision_row, 19);
        step();

        // Asynchronous reset mid-fall, then a fresh spawn with a coincident tick.
        spawn(0);
        ticks(8);
        chk("s5_row8", piece_row, 8);
        reset_dut();
        start = 1'b1; ptype = 3'd5; tick = 1'b1;
        step();
        start = 1'b0; tick = 1'b0;
        step();
        chk("s5_respawn_row", piece_row, 0);
        chk("s5_respawn_busy", busy, 1'b1);
        tick_until_landed(40, n);
        chk("s5_coll", collision_row, 19);
        step();

        // Random play against the model, with the board changing under the piece.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0) rand_board();
            if ((m_go && $urandom_range(0, 7) == 0) || $urandom_range(0, 999) == 0)
                reset_dut();
            start = ($urandom_range(0, 5) == 0);
            ptype = 3'($urandom_range(0, 7));
            tick  = ($urandom_range(0, 2) == 0);
            step();
        end
        start = 1'b0; tick = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
